debounce_scheduler: RTL and testbench
=====================================

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 Parameter N_CH, default 4: number of switch channels sharing one debounce timer.
REQ-002 Parameter CNT_BITS, default 19: timer width; the debounce period is 2^CNT_BITS clocks (about 10.5 ms at 50 MHz).
REQ-003 clk_i  input  1  the single 50 MHz clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 noisy_i  input  N_CH  raw switch levels, one bit per channel.
REQ-006 clean_o  output  N_CH  debounced switch states.
REQ-007 changed_o  output  N_CH  one-cycle pulse on the channel whose clean_o bit updated in that cycle.
REQ-008 busy_o  output  1  high whenever the timer is allocated (state is not IDLE).
REQ-009 grant_o  output  clog2(N_CH)  index of the channel holding the timer; valid only while busy_o is high, and 0 otherwise.

Function
REQ-010 Each edge SHALL register noisy_i into sw_now[N_CH-1:0]; all decisions SHALL use sw_now, never noisy_i directly.
REQ-011 Channel i requests the timer when sw_now[i] != clean_o[i].
REQ-012 The FSM SHALL have exactly three states: IDLE, TIMING and COMMIT.
REQ-013 IDLE, with any request present: grant the first requesting channel at or after rr_ptr (searching upward, modulo N_CH); clear cnt to 0; go to TIMING.
REQ-014 IDLE, with no request present: remain in IDLE.
REQ-015 TIMING, when sw_now[grant] == clean_o[grant] (bounce back): abort; set rr_ptr to (grant+1) mod N_CH; clear cnt; go to IDLE; clean_o is unchanged.
REQ-016 TIMING, otherwise: increment cnt; when cnt is all ones (2^CNT_BITS-1), go to COMMIT; cnt SHALL never wrap past all ones.
REQ-017 COMMIT: set clean_o[grant] to sw_now[grant]; pulse changed_o[grant] high for this one cycle; set rr_ptr to (grant+1) mod N_CH; go to IDLE.
REQ-018 Uncontended latency: a noisy_i step captured on edge 0 SHALL give grant on edge 1, COMMIT entry on edge 2^CNT_BITS+1, and the clean_o update on edge 2^CNT_BITS+2.
REQ-019 Requests from non-granted channels SHALL wait without timing; a granted timing run SHALL NOT be preempted.
REQ-020 A channel whose sw_now returns to its clean_o level while it is waiting SHALL simply drop its request.
REQ-021 Each channel's clean_o bit SHALL change only in COMMIT, and at most one bit SHALL change per cycle.
REQ-022 Starvation bound: any persistent request SHALL be granted within N_CH-1 completed or aborted runs.

Reset
REQ-023 While rst_i is high at an edge, the block SHALL set clean_o, changed_o, sw_now, cnt and rr_ptr to 0, force state to IDLE, and drive busy_o and grant_o to 0.
REQ-024 Reset SHALL take priority over every FSM transition, including assertion mid-TIMING or in COMMIT; a run interrupted by reset SHALL NOT commit.
REQ-025 After rst_i deasserts, any input already high SHALL be re-timed for the full period.

Structure
REQ-026 Shared package debounce_pkg SHALL hold the FSM state encoding (IDLE=0, TIMING=1, COMMIT=2) and the default values of N_CH and CNT_BITS.
REQ-027 Round-robin selection SHALL live in one combinational sub-module, rr_picker (inputs: request vector and pointer; outputs: index and valid).
REQ-028 The block SHALL contain a single counter of CNT_BITS bits, with no per-channel counters.

Verification (CNT_BITS=3, N_CH=4)
REQ-029 Raise noisy_i[0] after reset -> grant_o=0 and busy_o high from edge 1; clean_o[0]=1 and changed_o=0001 for exactly one cycle at edge 10; busy_o low at edge 11.
REQ-030 Raise noisy_i[1] for 5 clocks, then lower it -> run aborts; clean_o stays 0000; changed_o never pulses; rr_ptr becomes 2.
REQ-031 Raise noisy_i[0] and noisy_i[2] on the same edge with rr_ptr=0 -> ch0 commits at edge 10; ch2 is granted at edge 11 and commits at edge 20.
REQ-032 Keep ch3 pending while ch0 commits, then toggle ch0 again -> ch3 is granted before ch0's second run.
REQ-033 Assert rst_i at cnt=4 with noisy_i=0001 held -> next edge gives all outputs 0; after release, clean_o[0] rises at edge 10 relative to release.
REQ-034 Hold noisy_i=1111 after reset -> channels commit in order 0,1,2,3, 10 edges apart; cnt never exceeds 7.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and FSM encoding for the debounce scheduler
package debounce_pkg;

    localparam int N_CH_DEF     = 4;
    localparam int CNT_BITS_DEF = 19;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TIMING = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first request at or above the pointer
module rr_picker
    import debounce_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [2*N_CH-1:0] w_rot;

    assign w_rot = {i_req, i_req} >> i_ptr;

    // Walk downward so the lowest offset from the pointer is written last and wins.
    always_comb begin
        int sum;
        o_idx   = '0;
        o_valid = 1'b0;
        sum     = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                sum = int'(i_ptr) + k;
                if (sum >= N_CH) begin
                    sum = sum - N_CH;
                end
                o_idx   = IDX_W'(sum);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - N-channel switch debouncer sharing one timer, granted round-robin
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int  N_CH     = N_CH_DEF,
    parameter int  CNT_BITS = CNT_BITS_DEF,
    localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_CH-1:0]  noisy_i,
    output logic [N_CH-1:0]  clean_o,
    output logic [N_CH-1:0]  changed_o,
    output logic             busy_o,
    output logic [IDX_W-1:0] grant_o
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_CH-1:0]    r_sw_now;
    logic [N_CH-1:0]    r_clean;
    logic [N_CH-1:0]    r_changed;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   w_grant_inc;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [N_CH-1:0]    w_req;
    logic [N_CH-1:0]    w_grant_onehot;

    assign w_req          = r_sw_now ^ r_clean;
    assign w_grant_inc    = (r_grant == IDX_W'(N_CH - 1)) ? '0 : r_grant + IDX_W'(1);
    assign w_grant_onehot = N_CH'(1) << r_grant;

    rr_picker #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_ptr;
        w_grant_nxt = r_grant;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = TIMING;
                end
            end
            TIMING: begin
                // A bounce back to the committed level gives up the timer immediately.
                if (r_sw_now[r_grant] == r_clean[r_grant]) begin
                    w_rr_nxt    = w_grant_inc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == '1) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_BITS'(1);
                end
            end
            COMMIT: begin
                w_rr_nxt    = w_grant_inc;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sw_now  <= '0;
            r_clean   <= '0;
            r_changed <= '0;
            r_cnt     <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
        end else begin
            r_sw_now  <= noisy_i;
            r_cnt     <= w_cnt_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_grant   <= w_grant_nxt;
            r_changed <= '0;
            if (r_state == COMMIT) begin
                r_clean[r_grant] <= r_sw_now[r_grant];
                r_changed        <= w_grant_onehot;
            end
        end
    end

    assign clean_o   = r_clean;
    assign changed_o = r_changed;
    assign busy_o    = (r_state != IDLE);
    assign grant_o   = busy_o ? r_grant : '0;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - scoreboard bench for debounce_scheduler with CNT_BITS=3, N_CH=4
module tb_debounce_scheduler;

    localparam int N_CH     = 4;
    localparam int CNT_BITS = 3;

    logic             clk;
    logic             rst;
    logic [N_CH-1:0]  noisy;
    logic [N_CH-1:0]  clean_o;
    logic [N_CH-1:0]  changed_o;
    logic             busy_o;
    logic [1:0]       grant_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int   ch;
        logic val;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [N_CH-1:0] mon_onehot;

    debounce_scheduler #(
        .N_CH     (N_CH),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .noisy_i   (noisy),
        .clean_o   (clean_o),
        .changed_o (changed_o),
        .busy_o    (busy_o),
        .grant_o   (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every changed_o pulse must match the oldest expected commit: channel, level and cycle.
    always @(negedge clk) begin
        if (!rst && changed_o != '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse changed_o=%b clean_o=%b cyc=%0d", changed_o, clean_o, cyc);
            end else begin
                mon_e      = sb.pop_front();
                mon_onehot = 4'b0001 << mon_e.ch;
                if (changed_o !== mon_onehot || clean_o[mon_e.ch] !== mon_e.val || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL commit_ch%0d changed_o=%b clean_bit=%b cyc=%0d expected changed_o=%b clean_bit=%b cyc=%0d",
                             mon_e.ch, changed_o, clean_o[mon_e.ch], cyc, mon_onehot, mon_e.val, mon_e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input int ch, input logic val, input int at_cyc);
        exp_t e;
        e.ch  = ch;
        e.val = val;
        e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        noisy = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic finish_sb(input string name);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d outstanding commits expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        noisy = 4'b1111;
        repeat (3) @(negedge clk);
        checks++;
        if (clean_o !== 4'b0000) begin errors++; $display("FAIL reset_clean got %b expected 0000", clean_o); end
        checks++;
        if (changed_o !== 4'b0000) begin errors++; $display("FAIL reset_changed got %b expected 0000", changed_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_o); end
        checks++;
        if (grant_o !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d expected 0", grant_o); end
        noisy = '0;
        rst   = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        noisy = 4'b0001;
        push_exp(0, 1'b1, cyc + 11);
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || grant_o !== 2'd0) begin
            errors++; $display("FAIL single_grant busy=%b grant=%0d expected busy=1 grant=0", busy_o, grant_o);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (clean_o !== 4'b0000) begin errors++; $display("FAIL single_early clean=%b expected 0000", clean_o); end
        @(negedge clk);
        checks++;
        if (clean_o !== 4'b0001) begin errors++; $display("FAIL single_commit clean=%b expected 0001", clean_o); end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || changed_o !== 4'b0000) begin
            errors++; $display("FAIL single_after busy=%b changed=%b expected busy=0 changed=0000", busy_o, changed_o);
        end
        finish_sb("single");
    endtask

    task automatic test_abort();
        int c2;
        do_reset();
        noisy = 4'b0010;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || grant_o !== 2'd1) begin
            errors++; $display("FAIL abort_grant busy=%b grant=%0d expected busy=1 grant=1", busy_o, grant_o);
        end
        repeat (3) @(negedge clk);
        noisy = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || clean_o !== 4'b0000) begin
            errors++; $display("FAIL abort_idle busy=%b clean=%b expected busy=0 clean=0000", busy_o, clean_o);
        end
        // Pointer now sits at 2, so ch3 must win over ch0.
        c2    = cyc;
        noisy = 4'b1001;
        push_exp(3, 1'b1, c2 + 11);
        push_exp(0, 1'b1, c2 + 21);
        repeat (2) @(negedge clk);
        checks++;
        if (grant_o !== 2'd3) begin errors++; $display("FAIL abort_rr_ptr grant=%0d expected 3", grant_o); end
        repeat (20) @(negedge clk);
        finish_sb("abort");
    endtask

    task automatic test_pair();
        int c;
        do_reset();
        c     = cyc;
        noisy = 4'b0101;
        push_exp(0, 1'b1, c + 11);
        push_exp(2, 1'b1, c + 21);
        repeat (12) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || grant_o !== 2'd2) begin
            errors++; $display("FAIL pair_second_grant busy=%b grant=%0d expected busy=1 grant=2", busy_o, grant_o);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (clean_o !== 4'b0101) begin errors++; $display("FAIL pair_clean clean=%b expected 0101", clean_o); end
        finish_sb("pair");
    endtask

    task automatic test_fairness();
        int c;
        do_reset();
        c     = cyc;
        noisy = 4'b0001;
        push_exp(0, 1'b1, c + 11);
        repeat (3) @(negedge clk);
        noisy = 4'b1001;
        push_exp(3, 1'b1, c + 21);
        repeat (7) @(negedge clk);
        noisy = 4'b1000;
        push_exp(0, 1'b0, c + 31);
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || grant_o !== 2'd3) begin
            errors++; $display("FAIL fair_grant busy=%b grant=%0d expected busy=1 grant=3", busy_o, grant_o);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (clean_o !== 4'b1000) begin errors++; $display("FAIL fair_clean clean=%b expected 1000", clean_o); end
        finish_sb("fair");
    endtask

    task automatic test_reset_mid();
        do_reset();
        noisy = 4'b0001;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || grant_o !== 2'd0 || clean_o !== 4'b0000 || changed_o !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_outputs busy=%b grant=%0d clean=%b changed=%b expected all 0",
                     busy_o, grant_o, clean_o, changed_o);
        end
        rst = 1'b0;
        push_exp(0, 1'b1, cyc + 11);
        repeat (12) @(negedge clk);
        checks++;
        if (clean_o !== 4'b0001) begin errors++; $display("FAIL midrst_clean clean=%b expected 0001", clean_o); end
        finish_sb("midrst");
    endtask

    task automatic test_all_channels();
        int c;
        do_reset();
        c     = cyc;
        noisy = 4'b1111;
        for (int i = 0; i < N_CH; i++) begin
            push_exp(i, 1'b1, c + 11 + 10 * i);
        end
        repeat (42) @(negedge clk);
        checks++;
        if (clean_o !== 4'b1111 || busy_o !== 1'b0) begin
            errors++; $display("FAIL all_clean clean=%b busy=%b expected clean=1111 busy=0", clean_o, busy_o);
        end
        finish_sb("all");
    endtask

    initial begin
        rst   = 1'b1;
        noisy = '0;
        test_reset();
        test_single();
        test_abort();
        test_pair();
        test_fairness();
        test_reset_mid();
        test_all_channels();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
